slice_rotate_engine: RTL
========================

# slice_rotate_engine

Parametrised successor to the fixed 25×64 rotate block. It reads a state matrix slice by slice (D = 2^LOG_DEPTH slices of N bits each, one slice per address) and rotates every lane k (bit k of each slice) along the depth axis by a per-lane offset. It writes the rotated slices back through a write port with backpressure. Direction is selectable per run, so a forward (rho-style) rotation and its inverse share one block. It sits between the slice-organised state memory and the encoder datapath.

## Interface
- N_LANES, 25, lanes per slice (bit width of a slice)
- LOG_DEPTH, 6, log2 of slice count; D = 2^LOG_DEPTH
- OFFSETS, KECCAK_RHO_OFFSETS, packed N_LANES×LOG_DEPTH vector; field k = offset of lane k (k = 5y+x for default)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rotate_en  in  1  start request; sampled only in IDLE or DONE
- dir  in  1  0 = forward, 1 = inverse; latched with rotate_en
- busy  out  1  high in LOAD, WRITE, DONE
- donee  out  1  one-cycle completion pulse
- cnt_value  out  LOG_DEPTH  read slice address
- line_in  in  N_LANES  read data, combinational from cnt_value in the same cycle
- write_enable  out  1  write valid
- write_ready  in  1  write accepted when write_enable & write_ready at the edge
- write_addr  out  LOG_DEPTH  write slice address
- write_value  out  N_LANES  rotated slice

## Operation
- FSM states:
  - IDLE: on rotate_en → LOAD, latch dir, cnt_value←0.
  - LOAD: at each edge, buf[cnt_value]←line_in and cnt_value increments. The capture at cnt_value = D−1 moves to WRITE, with write_addr←0 and cnt_value wrapping to 0.
  - WRITE: write_enable=1. Each accepted write increments write_addr. The accept at D−1 moves to DONE.
  - DONE: donee=1 for one cycle, then → IDLE. If rotate_en is high in DONE, go directly to LOAD (back-to-back); donee still pulses.
- rotate_en in LOAD or WRITE is ignored and not queued.
- Rotation, forward: write_value[k] = buf[(write_addr − off_k) mod D][k].
- Rotation, inverse: write_value[k] = buf[(write_addr + off_k) mod D][k].
- mod D is LOG_DEPTH-bit truncation. Offsets ≥ D are illegal; elaboration asserts this.
- buf is N_LANES×D flops and is not reset.

## Timing
- Reset values: busy=0, donee=0, cnt_value=0, write_enable=0, write_addr=0, write_value=0, state IDLE.
- Reset mid-run aborts immediately. Outputs go to their reset values, no donee is issued, and a partial write sequence is abandoned.
- Latency with write_ready held at 1 (edge e0 samples rotate_en):
  - edges e1..eD capture slices 0..D−1;
  - edges eD+1..e2D accept writes 0..D−1;
  - donee is high between e2D and e2D+1.
  - Total: 2D+1 cycles start to done; 129 cycles for the default.
- write_ready low: write_addr and write_value hold stable and write_enable stays 1. The stall has no limit.
- write_value is registered or combinational from buf/write_addr. Either way it must be valid whenever write_enable=1.

## Structure
- Package rotate_pkg holds:
  - state enum {IDLE, LOAD, WRITE, DONE};
  - default LOG_DEPTH and N_LANES;
  - KECCAK_RHO_OFFSETS, lanes 0..24 = 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14.
- Sub-module rotate_slice_gather: purely combinational. Inputs are buf, write_addr, dir and OFFSETS; output is write_value. Parametrised like the top.
- Top: FSM, counters, buf.

## Test plan
- Reset: assert rst mid-cycle with no clock → all outputs 0 immediately; release, hold rotate_en=0 for 10 cycles → busy stays 0.
- Impulse, forward, default params: slice 0 = 25'h1FFFFFF, others 0, dir=0, write_ready=1 →
  - addr 0 = 25'h0000001; addr 1 = 25'h0000002; addr 62 = 25'h0000004; addr 61 = 25'h0400000;
  - addr 14 = 25'h1000000; addr 5 = 25'h0000000;
  - donee 129 cycles after start.
- Round trip: random 64×25 input, forward run, feed the output back with dir=1 → output equals the original exactly.
- Backpressure: write_ready pseudo-random at 50% → exactly 64 accepts with addresses 0..63 in order; values identical to the write_ready=1 run; write_addr/write_value stable while stalled; donee only after accept 63.
- Reset mid-WRITE at write_addr=30 → next cycle write_enable=0, no donee; a fresh start then produces a correct full run.
- Small config N_LANES=4, LOG_DEPTH=3, OFFSETS={7,3,1,0}: slice 0 = 4'hF → addr0 = 4'h1, addr1 = 4'h2, addr3 = 4'h4, addr7 = 4'h8. A rotate_en held through the whole run starts the second run from DONE.

Source files
------------

// File: rtl/rotate_pkg.sv
// ============================================================================
// Module      : rotate_pkg
// Description : Shared types and defaults for the slice rotate engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rotate_pkg;

  localparam int DEFAULT_N_LANES   = 25;
  localparam int DEFAULT_LOG_DEPTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Field k (bits k*6 +: 6) is the rho offset of lane k = 5y+x; lane 24 first.
  localparam logic [DEFAULT_N_LANES*DEFAULT_LOG_DEPTH-1:0] KECCAK_RHO_OFFSETS = {
    6'd14, 6'd56, 6'd61, 6'd2,  6'd18,
    6'd8,  6'd21, 6'd15, 6'd45, 6'd41,
    6'd39, 6'd25, 6'd43, 6'd10, 6'd3,
    6'd20, 6'd55, 6'd6,  6'd44, 6'd36,
    6'd27, 6'd28, 6'd62, 6'd1,  6'd0
  };

endpackage

`default_nettype wire

// File: rtl/slice_rotate_engine_if.sv
// ============================================================================
// Module      : slice_rotate_engine_if
// Description : Control, slice-read and slice-write signals of the engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface slice_rotate_engine_if
  import rotate_pkg::*;
#(
  parameter int N_LANES   = DEFAULT_N_LANES,
  parameter int LOG_DEPTH = DEFAULT_LOG_DEPTH
);

  logic                 rotate_en;
  logic                 dir;
  logic                 busy;
  logic                 donee;
  logic [LOG_DEPTH-1:0] cnt_value;
  logic [N_LANES-1:0]   line_in;
  logic                 write_enable;
  logic                 write_ready;
  logic [LOG_DEPTH-1:0] write_addr;
  logic [N_LANES-1:0]   write_value;

  modport slave (
    input  rotate_en, dir, line_in, write_ready,
    output busy, donee, cnt_value, write_enable, write_addr, write_value
  );

  modport master (
    output rotate_en, dir, line_in, write_ready,
    input  busy, donee, cnt_value, write_enable, write_addr, write_value
  );

endinterface

`default_nettype wire

// File: rtl/rotate_slice_gather.sv
// ============================================================================
// Module      : rotate_slice_gather
// Description : Combinational per-lane gather that forms one rotated slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotate_slice_gather
  import rotate_pkg::*;
#(
  parameter int N_LANES   = DEFAULT_N_LANES,
  parameter int LOG_DEPTH = DEFAULT_LOG_DEPTH,
  parameter logic [N_LANES*LOG_DEPTH-1:0] OFFSETS = KECCAK_RHO_OFFSETS
) (
  input  wire logic [(1<<LOG_DEPTH)-1:0][N_LANES-1:0] slices,
  input  wire logic [LOG_DEPTH-1:0]                   write_addr,
  input  wire logic                                   dir,
  output logic      [N_LANES-1:0]                     write_value
);

  // Offsets are LOG_DEPTH-bit fields, so an offset >= D cannot be expressed;
  // the address arithmetic wraps modulo D by truncation.
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    localparam logic [LOG_DEPTH-1:0] C_OFF = OFFSETS[k*LOG_DEPTH +: LOG_DEPTH];
    logic [LOG_DEPTH-1:0] w_src;

    assign w_src          = dir ? (write_addr + C_OFF) : (write_addr - C_OFF);
    assign write_value[k] = slices[w_src][k];
  end

endmodule

`default_nettype wire

// File: rtl/slice_rotate_engine.sv
// ============================================================================
// Module      : slice_rotate_engine
// Description : Loads D slices, then writes them back with every lane rotated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_rotate_engine
  import rotate_pkg::*;
#(
  parameter int N_LANES   = DEFAULT_N_LANES,
  parameter int LOG_DEPTH = DEFAULT_LOG_DEPTH,
  parameter logic [N_LANES*LOG_DEPTH-1:0] OFFSETS = KECCAK_RHO_OFFSETS
) (
  input wire logic             clk,
  input wire logic             rst,
  slice_rotate_engine_if.slave bus
);

  localparam int                   C_DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH-1:0] C_LAST  = LOG_DEPTH'(C_DEPTH - 1);
  localparam logic [LOG_DEPTH-1:0] C_ONE   = LOG_DEPTH'(1);

  state_e                           r_state;
  state_e                           w_next;
  logic                             w_start;
  logic                             w_accept;
  logic [LOG_DEPTH-1:0]             r_cnt;
  logic [LOG_DEPTH-1:0]             r_waddr;
  logic                             r_dir;
  logic [C_DEPTH-1:0][N_LANES-1:0]  r_slice_buf;
  logic [N_LANES-1:0]               w_gathered;

  assign w_accept = (r_state == WRITE) && bus.write_ready;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.rotate_en) begin
          w_next  = LOAD;
          w_start = 1'b1;
        end
      end
      LOAD: begin
        if (r_cnt == C_LAST) w_next = WRITE;
      end
      WRITE: begin
        if (w_accept && (r_waddr == C_LAST)) w_next = DONE;
      end
      DONE: begin
        // Back-to-back runs restart straight from DONE.
        if (bus.rotate_en) begin
          w_next  = LOAD;
          w_start = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt <= '0;
        r_dir <= bus.dir;
      end else if (r_state == LOAD) begin
        r_cnt <= r_cnt + C_ONE;
        if (r_cnt == C_LAST) r_waddr <= '0;
      end else if (w_accept) begin
        r_waddr <= r_waddr + C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == LOAD) r_slice_buf[r_cnt] <= bus.line_in;
  end

  rotate_slice_gather #(
    .N_LANES   (N_LANES),
    .LOG_DEPTH (LOG_DEPTH),
    .OFFSETS   (OFFSETS)
  ) u_gather (
    .slices      (r_slice_buf),
    .write_addr  (r_waddr),
    .dir         (r_dir),
    .write_value (w_gathered)
  );

  assign bus.busy         = (r_state != IDLE);
  assign bus.donee        = (r_state == DONE);
  assign bus.write_enable = (r_state == WRITE);
  assign bus.cnt_value    = r_cnt;
  assign bus.write_addr   = r_waddr;
  // Gate the gather so the unreset buffer never reaches the port outside WRITE.
  assign bus.write_value  = (r_state == WRITE) ? w_gathered : '0;

endmodule

`default_nettype wire
